// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between a command producer / ALU / response consumer and alu_cmd_sequencer.
// The sequencer binds to the slave modport; the environment around it uses master.
interface alu_cmd_sequencer_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 32,
  parameter int FIFO_DEPTH   = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // command port
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [DATA_WIDTH-1:0]   cmd_a;
  logic [DATA_WIDTH-1:0]   cmd_b;
  logic [2:0]              cmd_op;

  // ALU side
  logic [DATA_WIDTH-1:0]   alu_a;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic [2:0]              alu_op_sel;
  logic                    alu_start_op;
  logic                    alu_end_op;
  logic [RESULT_WIDTH-1:0] alu_result;

  // response port
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [RESULT_WIDTH-1:0] rsp_result;
  logic [2:0]              rsp_op;
  logic                    rsp_timeout;

  // status
  logic                    busy;
  logic [CNT_W-1:0]        fifo_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  alu_end_op, alu_result,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_op_sel, alu_start_op,
    output rsp_valid, rsp_result, rsp_op, rsp_timeout,
    output busy, fifo_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output alu_end_op, alu_result,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op_sel, alu_start_op,
    input  rsp_valid, rsp_result, rsp_op, rsp_timeout,
    input  busy, fifo_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for cascaded_alu: queues operand/opcode commands, issues them one at a
// time with a start pulse, waits for end_op (or a watchdog) and hands back the result.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 15
) (
  input logic                 clk,
  input logic                 rst,
  alu_cmd_sequencer_if.slave  bus
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int WDOG_W  = $clog2(TIMEOUT);
  localparam int ENTRY_W = 2 * DATA_WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [ENTRY_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic                    r_ready_en;

  logic [DATA_WIDTH-1:0]   r_alu_a;
  logic [DATA_WIDTH-1:0]   r_alu_b;
  logic [2:0]              r_alu_op;

  logic [WDOG_W-1:0]       r_wdog;
  logic [WDOG_W-1:0]       w_wdog_next;
  logic [RESULT_WIDTH-1:0] r_rsp_result;
  logic [RESULT_WIDTH-1:0] w_rsp_result_next;
  logic                    r_rsp_timeout;
  logic                    w_rsp_timeout_next;
  logic                    w_start;

  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;

  // cmd_ready is gated by r_ready_en so it stays low throughout reset and rises one cycle later
  assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
  assign bus.cmd_ready = r_ready_en && !w_full;
  assign w_push        = bus.cmd_valid && bus.cmd_ready;
  assign w_pop         = (r_state == S_IDLE) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.cmd_op, bus.cmd_b, bus.cmd_a};
  end

  // Operand registers double as the FIFO's registered read port and hold until the next pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (w_pop) begin
      {r_alu_op, r_alu_b, r_alu_a} <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wdog        <= '0;
      r_rsp_result  <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_wdog        <= w_wdog_next;
      r_rsp_result  <= w_rsp_result_next;
      r_rsp_timeout <= w_rsp_timeout_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_wdog_next        = r_wdog;
    w_rsp_result_next  = r_rsp_result;
    w_rsp_timeout_next = r_rsp_timeout;
    w_start            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_start      = 1'b1;
        w_wdog_next  = '0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // a completion in the final watchdog cycle still wins over the timeout
        if (bus.alu_end_op) begin
          w_rsp_result_next  = bus.alu_result;
          w_rsp_timeout_next = 1'b0;
          w_state_next       = S_RESP;
        end else if (r_wdog == WDOG_W'(TIMEOUT - 1)) begin
          w_rsp_result_next  = '0;
          w_rsp_timeout_next = 1'b1;
          w_state_next       = S_RESP;
        end else begin
          w_wdog_next = r_wdog + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_op_sel   = r_alu_op;
  assign bus.alu_start_op = w_start;
  assign bus.rsp_valid    = (r_state == S_RESP);
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_op       = r_alu_op;
  assign bus.rsp_timeout  = r_rsp_timeout;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.fifo_count   = r_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed scenarios plus random traffic, with a behavioural
// ALU stub and an in-order expected-response queue built from accepted commands.
module tb_alu_cmd_sequencer;

  localparam int DW    = 16;
  localparam int RW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic clk;
  logic rst;

  alu_cmd_sequencer_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .FIFO_DEPTH(DEPTH)) bus_if ();

  alu_cmd_sequencer #(
    .DATA_WIDTH  (DW),
    .RESULT_WIDTH(RW),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT     (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int n_rsp  = 0;
  int n_start = 0;
  int alu_mode = 0;   // 0 normal ALU, 1 end_op never comes, 2 end_op arrives after the watchdog

  typedef struct {
    logic [RW-1:0] res;
    logic [2:0]    op;
    logic          to;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [RW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [RW-1:0] xa;
    logic [RW-1:0] xb;
    xa = RW'(a);
    xb = RW'(b);
    case (op)
      3'd0:    return xa * xb;
      3'd1:    return xa + xb;
      3'd2:    return xa - xb;
      3'd3:    return xa & xb;
      3'd4:    return xa | xb;
      3'd5:    return xa ^ xb;
      3'd6:    return {a, b};
      default: return {b, a};
    endcase
  endfunction

  // Behavioural ALU: 3-cycle multiply for op 000, 1 cycle otherwise
  initial begin
    logic [DW-1:0] sa, sb;
    logic [2:0]    sop;
    int            m, lat;
    bus_if.alu_end_op = 1'b0;
    bus_if.alu_result = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus_if.alu_start_op) begin
        sa = bus_if.alu_a; sb = bus_if.alu_b; sop = bus_if.alu_op_sel; m = alu_mode;
        if (m == 0)      lat = (sop == 3'd0) ? 3 : 1;
        else if (m == 2) lat = TMO + 2;
        else             lat = 0;
        if (lat != 0) begin
          repeat (lat) @(posedge clk);
          #1;
          bus_if.alu_end_op = 1'b1;
          bus_if.alu_result = alu_ref(sop, sa, sb);
          @(negedge clk);
          if (m == 0) check("operands_held", {bus_if.alu_op_sel, bus_if.alu_b, bus_if.alu_a},
                            {sop, sb, sa});
          @(posedge clk);
          #1;
          bus_if.alu_end_op = 1'b0;
          bus_if.alu_result = $urandom;
        end
      end
    end
  end

  // Scoreboard / protocol monitor
  logic          prev_hold  = 1'b0;
  logic          prev_start = 1'b0;
  logic [RW-1:0] prev_res;
  logic [2:0]    prev_op;
  logic          prev_to;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold  <= 1'b0;
      prev_start <= 1'b0;
    end else begin
      if (prev_hold)
        check("rsp_stable", {bus_if.rsp_valid, bus_if.rsp_timeout, bus_if.rsp_op, bus_if.rsp_result},
              {1'b1, prev_to, prev_op, prev_res});
      if (bus_if.alu_start_op) begin
        n_start++;
        if (prev_start) check("start_single_cycle", 1'b1, 1'b0);
      end
      prev_start <= bus_if.alu_start_op;
      if (bus_if.rsp_valid && bus_if.rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_result",  bus_if.rsp_result,  e.res);
          check("rsp_op",      bus_if.rsp_op,      e.op);
          check("rsp_timeout", bus_if.rsp_timeout, e.to);
        end
      end
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        exp_t e;
        e.op = bus_if.cmd_op;
        e.to = (alu_mode != 0);
        e.res = e.to ? '0 : alu_ref(bus_if.cmd_op, bus_if.cmd_a, bus_if.cmd_b);
        exp_q.push_back(e);
      end
      prev_hold <= bus_if.rsp_valid && !bus_if.rsp_ready;
      prev_res  <= bus_if.rsp_result;
      prev_op   <= bus_if.rsp_op;
      prev_to   <= bus_if.rsp_timeout;
    end
  end

  task automatic send_cmd(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op = op; bus_if.cmd_a = a; bus_if.cmd_b = b;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus_if.cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    check("cmd_accepted", ok, 1'b1);
  endtask

  task automatic wait_rsp(output int cycles);
    bit ok;
    ok = 1'b0;
    cycles = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      cycles++;
      if (bus_if.rsp_valid) begin ok = 1'b1; break; end
    end
    check("rsp_arrived", ok, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!bus_if.busy && bus_if.fifo_count == 0 && !bus_if.rsp_valid) begin ok = 1'b1; break; end
    end
    check("idle_reached", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1, "bench stalled");
  end

  initial begin
    int lat, snap_rsp, snap_start;
    rst = 1'b1;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_a = 16'd0; bus_if.cmd_b = 16'd0; bus_if.cmd_op = 3'd0;
    bus_if.rsp_ready = 1'b0;

    // Reset: outputs stay zero while rst is held even with cmd_valid high
    repeat (3) begin
      @(negedge clk);
      check("rst_outputs", {bus_if.cmd_ready, bus_if.rsp_valid, bus_if.busy, bus_if.alu_start_op,
                            bus_if.rsp_timeout, bus_if.fifo_count, bus_if.rsp_op, bus_if.alu_op_sel},
            '0);
      check("rst_data", {bus_if.rsp_result, bus_if.alu_a, bus_if.alu_b}, '0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cmd_ready_after_rst", bus_if.cmd_ready, 1'b1);
    check("fifo_empty_after_rst", bus_if.fifo_count, 0);

    // 3 + 5 add: four cycles from push to response, one start pulse
    bus_if.rsp_ready = 1'b1;
    snap_start = n_start;
    send_cmd(3'd1, 16'd3, 16'd5);
    wait_rsp(lat);
    check("min_latency", lat, 4);
    check("add_result", bus_if.rsp_result, 32'd8);
    check("add_op", bus_if.rsp_op, 3'd1);
    check("add_timeout", bus_if.rsp_timeout, 1'b0);
    wait_idle();
    check("one_start_pulse", n_start - snap_start, 1);

    // 3 * 4 multiply with the 3-cycle ALU path
    send_cmd(3'd0, 16'd3, 16'd4);
    wait_rsp(lat);
    check("mul_result", bus_if.rsp_result, 32'd12);
    wait_idle();

    // Backpressure: FIFO fills to DEPTH behind one stalled response
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_cmd(3'd4, 16'(i), 16'd1);
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op = 3'd4; bus_if.cmd_a = 16'd5; bus_if.cmd_b = 16'd1;
    repeat (3) @(negedge clk);
    check("full_cmd_ready", bus_if.cmd_ready, 1'b0);
    check("full_count", bus_if.fifo_count, DEPTH);
    check("full_rsp_held", bus_if.rsp_valid, 1'b1);
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    snap_rsp = n_rsp;
    bus_if.rsp_ready = 1'b1;
    wait_idle();
    check("backpressure_rsp_count", n_rsp - snap_rsp, 5);

    // Watchdog: no end_op at all
    alu_mode = 1;
    send_cmd(3'd2, 16'd9, 16'd7);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus_if.alu_start_op) begin seen = 1'b1; break; end
      end
      check("timeout_start_seen", seen, 1'b1);
    end
    wait_rsp(lat);
    check("timeout_wait_cycles", lat, TMO + 1);
    check("timeout_flag", bus_if.rsp_timeout, 1'b1);
    check("timeout_result", bus_if.rsp_result, 32'd0);
    wait_idle();

    // Late end_op lands while the timed-out response is still pending
    alu_mode = 2;
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b0;
    send_cmd(3'd5, 16'hA5A5, 16'h0F0F);
    wait_rsp(lat);
    repeat (4) @(negedge clk);
    check("late_endop_result", bus_if.rsp_result, 32'd0);
    check("late_endop_flag", bus_if.rsp_timeout, 1'b1);
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b1;
    wait_idle();
    alu_mode = 0;
    snap_rsp = n_rsp;
    send_cmd(3'd6, 16'h1234, 16'h5678);
    wait_rsp(lat);
    check("after_timeout_result", bus_if.rsp_result, 32'h12345678);
    wait_idle();
    check("after_timeout_count", n_rsp - snap_rsp, 1);

    // Reset while waiting with two commands queued
    alu_mode = 1;
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_cmd(3'd3, 16'($urandom), 16'($urandom));
    repeat (2) @(negedge clk);
    check("pre_rst_count", bus_if.fifo_count, 2);
    check("pre_rst_busy", {bus_if.busy, bus_if.rsp_valid}, 2'b10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    alu_mode = 0;
    @(negedge clk);
    check("abort_state", {bus_if.busy, bus_if.rsp_valid, bus_if.fifo_count}, '0);
    bus_if.rsp_ready = 1'b1;
    snap_rsp = n_rsp;
    repeat (30) @(negedge clk);
    check("no_stale_rsp", n_rsp - snap_rsp, 0);
    send_cmd(3'd7, 16'h00FF, 16'hFF00);
    wait_idle();
    check("post_abort_count", n_rsp - snap_rsp, 1);

    // Random traffic with random consumer stalls
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus_if.cmd_valid = ($urandom_range(0, 2) != 0);
      bus_if.cmd_op    = 3'($urandom);
      bus_if.cmd_a     = 16'($urandom);
      bus_if.cmd_b     = 16'($urandom);
      bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    wait_idle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
